// File: rtl/ula_ctrl.sv
// ula_ctrl: sequencing controller for the 8-bit ULA (register file, operand staging, write-back).
// Optional feature macro ULA_CTRL_FASTREAD_EN: fetch operands at accept and skip the READ state.
module ula_ctrl #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_op,
  input  logic [1:0] instr_ra,
  input  logic [1:0] instr_rb,
  input  logic       ld_en,
  input  logic [1:0] ld_idx,
  input  logic [7:0] ld_data,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [3:0] ula_select,
  input  logic [7:0] ula_s,
  output logic       done,
  output logic       illegal,
  output logic       zero,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0] OP_MAX = 4'd9;
  state_t          state_q, state_d;
  logic [3:0][7:0] r_q, r_d;
  logic [7:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]      sel_q, sel_d, cnt_q, cnt_d;
  logic [1:0]      ra_q, ra_d;
  logic            done_q, done_d, ill_q, ill_d, zero_q, zero_d;
`ifndef ULA_CTRL_FASTREAD_EN
  logic [3:0]      op_q, op_d;
  logic [1:0]      rb_q, rb_d;
`endif
  assign instr_ready = (state_q == IDLE) && !ld_en;
  assign ula_a       = a_q;
  assign ula_b       = b_q;
  assign ula_select  = sel_q;
  assign done        = done_q;
  assign illegal     = ill_q;
  assign zero        = zero_q;
  assign dbg_data    = r_q[dbg_sel];
  // next-state: loads and accepts in IDLE, operand staging, exec countdown, write-back
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
`ifndef ULA_CTRL_FASTREAD_EN
    op_d    = op_q;
    rb_d    = rb_q;
`endif
    case (state_q)
      IDLE: begin
        if (ld_en) begin
          r_d[ld_idx] = ld_data;
        end else if (instr_valid) begin
          ra_d = instr_ra;
          if (instr_op > OP_MAX) begin
            ill_d = 1'b1;
          end else begin
`ifdef ULA_CTRL_FASTREAD_EN
            a_d     = r_q[instr_ra];
            b_d     = r_q[instr_rb];
            sel_d   = instr_op;
            cnt_d   = '0;
            state_d = EXEC;
`else
            op_d    = instr_op;
            rb_d    = instr_rb;
            state_d = READ;
`endif
          end
        end
      end
`ifndef ULA_CTRL_FASTREAD_EN
      READ: begin
        a_d     = r_q[ra_q];
        b_d     = r_q[rb_q];
        sel_d   = op_q;
        cnt_d   = '0;
        state_d = EXEC;
      end
`endif
      EXEC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          res_d   = ula_s;
          state_d = WRITE;
        end
      end
      WRITE: begin
        r_d[ra_q] = res_q;
        zero_d    = (res_q == 8'h00);
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset discards any pending write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ra_q    <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifndef ULA_CTRL_FASTREAD_EN
      op_q    <= '0;
      rb_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
`ifndef ULA_CTRL_FASTREAD_EN
      op_q    <= op_d;
      rb_q    <= rb_d;
`endif
    end
  end
endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: table vectors, corner sequences and random instructions against a register-file model.
module tb_ula_ctrl;
  localparam int E = 3;
`ifdef ULA_CTRL_FASTREAD_EN
  localparam int LAT = 2 + E;
`else
  localparam int LAT = 3 + E;
`endif
  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready, ld_en, done, illegal, zero;
  logic [3:0] instr_op, ula_select;
  logic [1:0] instr_ra, instr_rb, ld_idx, dbg_sel;
  logic [7:0] ld_data, ula_a, ula_b, ula_s, dbg_data;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_r [4];
  logic       m_zero;
  logic [3:0] m_sel;
  typedef struct {
    logic [3:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [7:0] ula_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] w;
    w = {a, a} << b[2:0];
    case (s)
      4'd0: return ~b;
      4'd1: return a & b;
      4'd2: return a | b;
      4'd3: return a ^ b;
      4'd4: return a + b;
      4'd5: return a - b;
      4'd6: return a << b;
      4'd7: return a >> b;
      4'd8: return 8'(a * b);
      4'd9: return w[15:8];
      default: return 8'h00;
    endcase
  endfunction

  assign ula_s = ula_f(ula_select, ula_a, ula_b);

  ula_ctrl #(.EXEC_CYCLES(E)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_ra(instr_ra), .instr_rb(instr_rb), .ld_en(ld_en),
    .ld_idx(ld_idx), .ld_data(ld_data), .ula_a(ula_a), .ula_b(ula_b),
    .ula_select(ula_select), .ula_s(ula_s), .done(done), .illegal(illegal),
    .zero(zero), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk(name, dbg_data, m_r[i]);
    end
  endtask

  task automatic do_load(input logic [1:0] idx, input logic [7:0] d, input bit with_instr);
    ld_en = 1'b1; ld_idx = idx; ld_data = d;
    instr_valid = with_instr; instr_op = 4'd4; instr_ra = idx; instr_rb = idx;
    #1 chk("ld_ready_low", instr_ready, 1'b0);
    @(posedge clk); #1;
    ld_en = 1'b0; instr_valid = 1'b0;
    m_r[idx] = d;
    dbg_sel = idx;
    #1 chk("ld_dbg", dbg_data, d);
    if (with_instr) chk("collision_not_accepted", instr_ready, 1'b1);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                           input bit ld_mid, input logic [7:0] exp_res);
    int n;
    bit bad_ill, bad_rdy;
    logic [7:0] a0, b0;
    a0 = m_r[ra]; b0 = m_r[rb];
    bad_ill = 1'b0; bad_rdy = 1'b0;
    dbg_sel = ra; ld_en = 1'b0;
    instr_valid = 1'b1; instr_op = op; instr_ra = ra; instr_rb = rb;
    #1 chk("ready_idle", instr_ready, 1'b1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (op >= 4'd10) begin
      chk("illegal_pulse", illegal, 1'b1);
      chk("illegal_no_done", done, 1'b0);
      chk("illegal_ready", instr_ready, 1'b1);
      @(posedge clk); #1;
      chk("illegal_once", illegal, 1'b0);
      chk("illegal_no_done2", done, 1'b0);
      chk("illegal_zero", zero, m_zero);
      chk("illegal_sel", ula_select, m_sel);
      chk("illegal_ready2", instr_ready, 1'b1);
      chk_regs("illegal_regs");
      return;
    end
    n = 1;
    while (!done && n < 64) begin
      if (illegal) bad_ill = 1'b1;
      instr_valid = 1'($urandom_range(0, 1));
      instr_op = 4'($urandom); instr_ra = 2'($urandom); instr_rb = 2'($urandom);
      if (ld_mid && n == 2) begin
        ld_en = 1'b1; ld_idx = ra + 2'd1; ld_data = ~m_r[ra + 2'd1];
      end else begin
        ld_en = 1'b0;
      end
      #1 if (instr_ready) bad_rdy = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    instr_valid = 1'b0; ld_en = 1'b0;
    chk("done_latency", n, LAT);
    chk("wb_dbg", dbg_data, exp_res);
    chk("zero_flag", zero, exp_res == 8'h00);
    chk("ula_a", ula_a, a0);
    chk("ula_b", ula_b, b0);
    chk("ula_select", ula_select, op);
    chk("no_illegal", bad_ill, 1'b0);
    chk("busy_not_ready", bad_rdy, 1'b0);
    #1 chk("ready_with_done", instr_ready, 1'b1);
    m_r[ra] = exp_res; m_zero = (exp_res == 8'h00); m_sel = op;
    @(posedge clk); #1;
    chk("done_pulse_once", done, 1'b0);
    chk_regs("regs_after");
  endtask

  initial begin
    bit seen_done;
    tbl[0]  = '{4'd4, 2'd0, 2'd1, 8'h47, 8'h02, 8'h49};
    tbl[1]  = '{4'd5, 2'd2, 2'd3, 8'h47, 8'h47, 8'h00};
    tbl[2]  = '{4'd0, 2'd2, 2'd3, 8'h00, 8'h47, 8'hB8};
    tbl[3]  = '{4'd9, 2'd0, 2'd1, 8'h47, 8'h0C, 8'h74};
    tbl[4]  = '{4'd1, 2'd1, 2'd2, 8'hF0, 8'h3C, 8'h30};
    tbl[5]  = '{4'd2, 2'd3, 2'd0, 8'h0F, 8'h30, 8'h3F};
    tbl[6]  = '{4'd3, 2'd1, 2'd1, 8'h5A, 8'h5A, 8'h00};
    tbl[7]  = '{4'd8, 2'd0, 2'd3, 8'h12, 8'h10, 8'h20};
    tbl[8]  = '{4'd6, 2'd2, 2'd1, 8'h81, 8'h03, 8'h08};
    tbl[9]  = '{4'd7, 2'd3, 2'd2, 8'h81, 8'h03, 8'h10};
    tbl[10] = '{4'd4, 2'd0, 2'd0, 8'h80, 8'h80, 8'h00};
    tbl[11] = '{4'd5, 2'd1, 2'd0, 8'h00, 8'h01, 8'hFF};
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_zero = 1'b0; m_sel = 4'd0;
    rst_n = 1'b0; instr_valid = 1'b0; ld_en = 1'b0; instr_op = 4'd0;
    instr_ra = 2'd0; instr_rb = 2'd0; ld_idx = 2'd0; ld_data = 8'h00; dbg_sel = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ula_a", ula_a, 8'h00);
    chk("rst_ula_b", ula_b, 8'h00);
    chk("rst_sel", ula_select, 4'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_ready", instr_ready, 1'b1);
    chk_regs("rst_regs");
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      do_load(tbl[i].ra, tbl[i].a, 1'b0);
      if (tbl[i].ra != tbl[i].rb) do_load(tbl[i].rb, tbl[i].b, 1'b0);
      run_instr(tbl[i].op, tbl[i].ra, tbl[i].rb, i == 3, tbl[i].res);
    end
    run_instr(4'd12, 2'd0, 2'd1, 1'b0, 8'h00);
    run_instr(4'd15, 2'd3, 2'd2, 1'b0, 8'h00);
    do_load(2'd2, 8'hC3, 1'b1);
    run_instr(4'd4, 2'd1, 2'd2, 1'b1, ula_f(4'd4, m_r[1], m_r[2]));
    do_load(2'd0, 8'h11, 1'b0);
    do_load(2'd1, 8'h22, 1'b0);
    run_instr(4'd3, 2'd2, 2'd2, 1'b0, 8'h00);
    dbg_sel = 2'd0; instr_valid = 1'b1; instr_op = 4'd4; instr_ra = 2'd0; instr_rb = 2'd1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_reset_busy", instr_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_zero = 1'b0; m_sel = 4'd0;
    chk("midrst_zero", zero, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_ula_a", ula_a, 8'h00);
    chk("midrst_ula_b", ula_b, 8'h00);
    chk("midrst_sel", ula_select, 4'd0);
    chk_regs("midrst_regs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("no_done_after_reset", seen_done, 1'b0);
    chk("ready_after_reset", instr_ready, 1'b1);
    chk_regs("regs_after_reset");
    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      logic [1:0] ra, rb;
      if ($urandom_range(0, 3) == 0) begin
        do_load(2'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        op = 4'($urandom_range(0, 15));
        ra = 2'($urandom);
        rb = 2'($urandom);
        run_instr(op, ra, rb, k % 7 == 0, ula_f(op, m_r[ra], m_r[rb]));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ula_ctrl.md
# ula_ctrl

Sequencing controller for the 8-bit ULA. It holds the four 8-bit architectural registers R[0..3] and accepts one ALU instruction at a time over a valid/ready handshake. For each instruction it drives the ULA operands and select, captures the result, and writes it back to R[ra], updating the zero flag. It sits between the instruction decode stage and the combinational ULA, which is instantiated outside this block.

## Interface
- EXEC_CYCLES, 1: cycles the ULA inputs are held before the result is sampled; legal range 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction request.
- instr_ready  out  1  combinational; equals (state==IDLE) && !ld_en.
- instr_op  in  4  ULA select code: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 SLR, 7 SRR, 8 MUL, 9 ROL; 10–15 illegal.
- instr_ra  in  2  destination register and operand a.
- instr_rb  in  2  operand b.
- ld_en  in  1  direct register load; honoured only in IDLE.
- ld_idx  in  2  load target register.
- ld_data  in  8  load value.
- ula_a  out  8  registered operand a to the ULA.
- ula_b  out  8  registered operand b to the ULA.
- ula_select  out  4  registered ULA select.
- ula_s  in  8  ULA result.
- done  out  1  one-cycle pulse when write-back occurs.
- illegal  out  1  one-cycle pulse when an illegal op is rejected.
- zero  out  1  set when the last written result was 0x00; sticky until the next write-back.
- dbg_sel  in  2  register select for the debug read port.
- dbg_data  out  8  combinational R[dbg_sel].

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- **IDLE**
  - ld_en=1 writes R[ld_idx] <= ld_data. No instruction is accepted that cycle, so load wins over instr_valid.
  - Otherwise, instr_valid && instr_ready is an accept: latch op, ra and rb.
    - Legal op: go to READ.
    - op >= 10: stay in IDLE, pulse illegal on the next cycle, leave registers, ula_* and zero unchanged, no done.
- **READ**: ula_a <= R[ra], ula_b <= R[rb], ula_select <= op; go to EXEC with exec counter = 0.
- **EXEC**: increment the counter. When counter == EXEC_CYCLES-1, capture result <= ula_s and go to WRITE.
- **WRITE**: R[ra] <= result, zero <= (result==8'h00), done=1; go to IDLE.
- Every op writes R[ra], including NOT, which uses only b.
- ra == rb is legal: both operands read the same register before the write.
- ula_a, ula_b and ula_select keep their last values after completion. They change only in READ (or at accept under FASTREAD).
- ld_en outside IDLE is ignored and dropped. instr_valid outside IDLE is not accepted, because instr_ready=0.
- Reset values: R[0..3]=0x00, ula_a=0x00, ula_b=0x00, ula_select=0, done=0, illegal=0, zero=0, state=IDLE, so instr_ready=1 when ld_en=0.
- Asserting rst_n low mid-operation immediately returns to IDLE with all reset values. A pending write-back is discarded and no done is issued.

## Timing
- Accept on edge 0.
  - READ completes at edge 1.
  - EXEC leaves at edge 1+EXEC_CYCLES.
  - WRITE completes at edge 2+EXEC_CYCLES.
- done is high in the cycle after the WRITE-state edge, coincident with instr_ready=1 again. That gives a latency of 3+EXEC_CYCLES cycles from accept to done.
- Back-to-back throughput: one instruction per 3+EXEC_CYCLES cycles. A new accept is allowed in the same cycle done is high.
- The new R[ra] value is visible on dbg_data in the same cycle done is high.
- illegal pulses exactly one cycle, in the cycle after the accept edge.

## Configuration
- ULA_CTRL_FASTREAD_EN defined:
  - READ is removed from the FSM.
  - On accept, ula_a, ula_b and ula_select load directly from R[instr_ra], R[instr_rb] and instr_op, and the FSM goes straight to EXEC.
  - Latency becomes 2+EXEC_CYCLES.
- ULA_CTRL_FASTREAD_EN undefined: the four-state behaviour above applies.

## Test plan
- **ADD:** load R0=0x47, R1=0x02; issue op 4, ra=0, rb=1, EXEC_CYCLES=1 -> done exactly 4 cycles after accept; R0=0x49; zero=0; ula_select=4.
- **SUB to zero:** load R2=0x47, R3=0x47; issue op 5, ra=2, rb=3 -> R2=0x00, zero=1. Then issue op 0 (NOT), ra=2, rb=3 -> R2=0xB8, zero=0.
- **ROL beyond one rotation:** load R0=0x47, R1=0x0C; issue op 9 -> R0=0x74.
- **Illegal op:** issue op 12 -> single illegal pulse the next cycle; no done; R0..R3 and zero unchanged; instr_ready stays 1 after the pulse.
- **Load/instruction collisions:**
  - ld_en=1 together with instr_valid=1 in IDLE -> load performed, instruction not accepted (instr_ready=0).
  - ld_en=1 during EXEC -> ignored, target register unchanged.
- **Reset mid-EXEC:** set EXEC_CYCLES=3 and assert rst_n=0 during EXEC -> all registers 0x00, no done, instr_ready=1 after release. Repeat the ADD test with ULA_CTRL_FASTREAD_EN defined -> done 3 cycles after accept.
